jk_seq_driver: RTL

- Active counterpart to the JK flip-flop bench: drives j/k into a jk_flipflop instance so that its q follows a programmed target bit sequence.
- Reads q/qbar back and checks each step.
- Reports pass/fail, error count and first failing index.
- Sits beside any JK-flop-based block as a reusable self-checking driver; synthesizable, one clock domain.

---
 rtl/jk_pkg.sv | 22 ++
 rtl/jk_excite.sv | 23 ++
 rtl/jk_seq_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK sequence driver: FSM states and {J,K} commands.
// Commands are encoded {J,K} so they can drive the flop pins directly.
package jk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      APPLY,
      CHECK,
      DONE
   } state_t;

   localparam logic [1:0] HOLD   = 2'b00;
   localparam logic [1:0] RESET  = 2'b01;
   localparam logic [1:0] SET    = 2'b10;
   localparam logic [1:0] TOGGLE = 2'b11;

   function automatic logic [1:0] abs_cmd(input logic t);
      return t ? SET : RESET;
   endfunction

endpackage

// File: rtl/jk_excite.sv
// Excitation table: picks the {J,K} command that moves q to target t.
// The first step is always absolute because q is not yet known.
module jk_excite
   import jk_pkg::*;
(
   input  logic       q,
   input  logic       t,
   input  logic       first,
   input  logic       toggle_mode,
   output logic [1:0] jk
);

   always_comb begin
      jk = HOLD;
      priority case (1'b1)
         first:       jk = abs_cmd(t);
         (q == t):    jk = HOLD;
         toggle_mode: jk = TOGGLE;
         default:     jk = abs_cmd(t);
      endcase
   end

endmodule

// File: rtl/jk_seq_driver.sv
// Drives a JK flop through a programmed bit sequence and checks q/qbar
// after every step, reporting pass, error count and first failing index.
module jk_seq_driver
   import jk_pkg::*;
#(
   parameter int SEQ_W       = 8,
   parameter int LEN_W       = 4,
   parameter int TOGGLE_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [SEQ_W-1:0] seq_bits,
   input  logic [LEN_W-1:0] seq_len,
   input  logic             q_fb,
   input  logic             qbar_fb,
   output logic             j,
   output logic             k,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [LEN_W-1:0] err_count,
   output logic [LEN_W-1:0] err_idx
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SEQ_W);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   state_t           state_q, state_d;
   logic [SEQ_W-1:0] bits_q, bits_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] err_cnt_q, err_cnt_d;
   logic [LEN_W-1:0] err_idx_q, err_idx_d;
   logic             pass_q, pass_d;
   logic [1:0]       jk_q, jk_d;

   logic [1:0]       jk_exc;
   logic [SEQ_W-1:0] bits_sh;
   logic [LEN_W-1:0] len_in;
   logic             xfer;
   logic             t;
   logic             fail;
   logic             last;

   assign xfer    = start_valid && start_ready;
   assign len_in  = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
   assign bits_sh = bits_q >> idx_q;
   assign t       = bits_sh[0];
   assign fail    = (q_fb != t) || (qbar_fb == q_fb);
   assign last    = (idx_q + ONE) >= len_q;

   jk_excite u_excite (
      .q           (q_fb),
      .t           (t),
      .first       (idx_q == '0),
      .toggle_mode (TOGGLE_MODE != 0),
      .jk          (jk_exc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer) state_d = (len_in == '0) ? DONE : DRIVE;
         DRIVE:   state_d = APPLY;
         APPLY:   state_d = CHECK;
         CHECK:   state_d = last ? DONE : DRIVE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state_q == IDLE);
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
   end

   always_comb begin
      bits_d    = bits_q;
      len_d     = len_q;
      idx_d     = idx_q;
      err_cnt_d = err_cnt_q;
      err_idx_d = err_idx_q;
      pass_d    = pass_q;
      jk_d      = HOLD;
      if (xfer) begin
         bits_d    = seq_bits;
         len_d     = len_in;
         idx_d     = '0;
         err_cnt_d = '0;
         err_idx_d = '0;
         pass_d    = (len_in == '0);
      end
      if (state_q == DRIVE) jk_d = jk_exc;
      // flop holds during CHECK, so q_fb is the settled result of this step
      if (state_q == CHECK) begin
         if (fail) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE;
            if (err_cnt_q == '0) err_idx_d = idx_q;
         end
         idx_d = idx_q + ONE;
         if (last) pass_d = (err_cnt_d == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         err_cnt_q <= '0;
         err_idx_q <= '0;
         pass_q    <= 1'b0;
         jk_q      <= HOLD;
      end else begin
         bits_q    <= bits_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         err_cnt_q <= err_cnt_d;
         err_idx_q <= err_idx_d;
         pass_q    <= pass_d;
         jk_q      <= jk_d;
      end
   end

   assign j         = jk_q[1];
   assign k         = jk_q[0];
   assign pass      = pass_q;
   assign err_count = err_cnt_q;
   assign err_idx   = err_idx_q;

endmodule
